// File: rtl/distance_filter_pkg.sv
// distance_filter_pkg: shared state type and widths for the distance filter
package distance_filter_pkg;
  typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;
  localparam int DIST_W = 6;
  function automatic int SUM_W(input int avg_log2);
    return DIST_W + avg_log2;
  endfunction
endpackage

// File: rtl/distance_filter_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle pulse every DIV clocks
module tick_gen #(
  parameter int DIV = 35000000
) (
  input  logic CLK50MHZ,
  input  logic RSTN,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] count;
  assign tick = count == LAST;
  always_ff @(posedge CLK50MHZ)
    count <= !RSTN || tick ? '0 : count + 1'b1;
endmodule

// File: rtl/distance_filter.sv
// distance_filter: moving average of sampled distances with miss flush and hysteretic proximity flag
module distance_filter
  import distance_filter_pkg::*;
#(
  parameter int SAMPLE_DIV = 35000000,
  parameter int AVG_LOG2   = 2,
  parameter int MISS_LIMIT = 3,
  parameter int NEAR_CM    = 10,
  parameter int FAR_CM     = 14
) (
  input  logic              CLK50MHZ,
  input  logic              RSTN,
  input  logic [DIST_W-1:0] dist_in,
  output logic              sample_tick,
  output logic [DIST_W-1:0] dist_avg,
  output logic              avg_valid,
  output logic              near,
  output logic              near_rise
);
  localparam int SW = SUM_W(AVG_LOG2);
  localparam int FW = AVG_LOG2 + 1;
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [MW-1:0] MLIM = MW'(MISS_LIMIT);
  localparam logic [DIST_W-1:0] NEAR_T = DIST_W'(NEAR_CM);
  localparam logic [DIST_W-1:0] FAR_T = DIST_W'(FAR_CM);
  state_t state;
  logic [DIST_W-1:0] ring [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [FW-1:0] fill, fill_n;
  logic [MW-1:0] miss, miss_n;
  logic [SW-1:0] sum;
  logic near_n;
  tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .CLK50MHZ(CLK50MHZ),
    .RSTN(RSTN),
    .tick(sample_tick)
  );
  always_comb begin
    fill_n = fill == FULL ? FULL : fill + 1'b1;
    miss_n = miss + 1'b1;
    near_n = avg_valid && dist_avg < NEAR_T ? 1'b1 : !avg_valid || dist_avg >= FAR_T ? 1'b0 : near;
  end
  always_ff @(posedge CLK50MHZ) begin
    if (!RSTN) begin
      state <= EMPTY;
      wr_ptr <= '0;
      fill <= '0;
      miss <= '0;
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      dist_avg <= '0;
      avg_valid <= 1'b0;
      near <= 1'b0;
      near_rise <= 1'b0;
    end else begin
      if (sample_tick && dist_in != '0) begin
        ring[wr_ptr] <= dist_in;
        sum <= sum - SW'(ring[wr_ptr]) + SW'(dist_in);
        wr_ptr <= wr_ptr + 1'b1;
        fill <= fill_n;
        miss <= '0;
        state <= fill_n == FULL ? RUN : FILL;
      end else if (sample_tick && miss_n == MLIM) begin
        for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
        sum <= '0;
        fill <= '0;
        wr_ptr <= '0;
        miss <= '0;
        state <= EMPTY;
      end else if (sample_tick) begin
        miss <= miss_n;
      end
      dist_avg <= state == RUN ? DIST_W'(sum >> AVG_LOG2) : '0;
      avg_valid <= state == RUN;
      near <= near_n;
      near_rise <= near_n && !near;
    end
  end
endmodule

// File: tb/tb_distance_filter.sv
// tb_distance_filter: randomized scoreboard bench against a window-list reference model
module tb_distance_filter;
  logic CLK50MHZ = 1'b0;
  logic RSTN = 1'b0;
  logic [5:0] dist_in = '0;
  logic sample_tick, avg_valid, near, near_rise;
  logic [5:0] dist_avg;
  int total = 0;
  int bad = 0;
  int rc = 0;
  typedef struct {int avg; int valid; int near; int rise;} exp_t;
  exp_t q[$];
  int win[$];
  int misses = 0;
  int mnear = 0;

  distance_filter #(.SAMPLE_DIV(4)) dut (
    .CLK50MHZ(CLK50MHZ),
    .RSTN(RSTN),
    .dist_in(dist_in),
    .sample_tick(sample_tick),
    .dist_avg(dist_avg),
    .avg_valid(avg_valid),
    .near(near),
    .near_rise(near_rise)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    misses = 0;
    mnear = 0;
    q.delete();
  endtask

  task automatic model(input int v, output exp_t e);
    int s;
    int prev;
    if (v != 0) begin
      win.push_back(v);
      if (win.size() > 4) void'(win.pop_front());
      misses = 0;
    end else begin
      misses++;
      if (misses == 3) begin
        win.delete();
        misses = 0;
      end
    end
    s = 0;
    foreach (win[i]) s += win[i];
    e.valid = win.size() == 4;
    e.avg = e.valid ? s / 4 : 0;
    prev = mnear;
    if (e.valid && e.avg < 10) mnear = 1;
    else if (!e.valid || e.avg >= 14) mnear = 0;
    e.near = mnear;
    e.rise = (prev == 0 && mnear == 1) ? 1 : 0;
  endtask

  task automatic sample(input int v);
    int n = 0;
    exp_t e;
    @(negedge CLK50MHZ);
    while (!sample_tick && n < 10) begin
      @(negedge CLK50MHZ);
      n++;
    end
    if (!sample_tick) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: no sample_tick within 10 cycles, required one");
      return;
    end
    dist_in = 6'(v);
    model(v, e);
    @(posedge CLK50MHZ);
    q.push_back(e);
    #1 dist_in = 6'($urandom_range(0, 63));
  endtask

  task automatic do_reset();
    @(posedge CLK50MHZ);
    #1 RSTN = 1'b0;
    model_reset();
    @(posedge CLK50MHZ);
    #1 RSTN = 1'b1;
  endtask

  always @(negedge CLK50MHZ) begin
    exp_t e;
    if (!RSTN) rc = 0;
    else begin
      if (near_rise) rc++;
      if (sample_tick && q.size() > 0) begin
        e = q.pop_front();
        chk("sb_avg", int'(dist_avg), e.avg);
        chk("sb_valid", int'(avg_valid), e.valid);
        chk("sb_near", int'(near), e.near);
        chk("sb_rise_count", rc, e.rise);
        rc = 0;
      end else if (sample_tick) rc = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (5) @(posedge CLK50MHZ);
    #1 RSTN = 1'b1;
    @(negedge CLK50MHZ);
    chk("reset_outputs", int'({dist_avg, avg_valid, near, near_rise}), 0);
    chk("reset_tick_c1", int'(sample_tick), 0);
    for (int i = 2; i <= 8; i++) begin
      @(negedge CLK50MHZ);
      chk($sformatf("reset_tick_c%0d", i), int'(sample_tick), (i % 4 == 0) ? 1 : 0);
    end
    foreach (win[i]) win[i] = 0;
    sample(20);
    sample(24);
    sample(28);
    sample(32);
    @(negedge CLK50MHZ);
    chk("lat_valid_t1", int'(avg_valid), 0);
    @(negedge CLK50MHZ);
    chk("lat_valid_t2", int'(avg_valid), 1);
    chk("lat_avg_t2", int'(dist_avg), 26);
    sample(40);
    sample(1);
    sample(1);
    sample(1);
    sample(2);
    repeat (4) sample(30);
    repeat (3) sample(8);
    sample(8);
    @(negedge CLK50MHZ);
    @(negedge CLK50MHZ);
    chk("near_t2", int'(near), 0);
    @(negedge CLK50MHZ);
    chk("near_t3", int'(near), 1);
    chk("near_rise_t3", int'(near_rise), 1);
    repeat (4) sample(12);
    repeat (4) sample(14);
    repeat (4) sample(9);
    sample(0);
    sample(0);
    sample(30);
    sample(0);
    sample(0);
    sample(0);
    repeat (4) sample(20);
    sample(33);
    sample(33);
    do_reset();
    repeat (4) sample(50);
    for (int i = 0; i < 60; i++)
      sample(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 63)));
    repeat (4) sample(63);
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(negedge CLK50MHZ);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
